// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg
// Shared definitions for the round-robin stream multiplexer:
//   state_e  - packet FSM state (no packet open / packet open on a locked channel)
//   mode_e   - decode of the force_en input (round-robin vs forced channel select)
//   sel_w()  - channel index width for a given channel count (at least 1 bit)
package stream_mux_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    typedef enum logic {
        MODE_RR    = 1'b0,
        MODE_FORCE = 1'b1
    } mode_e;

    function automatic int unsigned sel_w(input int unsigned num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Purely combinational round-robin arbiter. The request vector is rotated so
// that channel 'ptr' sits at bit 0, the lowest set bit is priority-encoded, and
// the resulting offset is rotated back into a channel index.
// Ports:
//   req          in   NUM_CH  request vector, one bit per channel
//   ptr          in   SEL_W   highest-priority channel (must be < NUM_CH)
//   grant        out  SEL_W   granted channel index (valid only with grant_valid)
//   grant_valid  out  1       at least one request present
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    localparam int unsigned SEL_W = sel_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  grant,
    output logic              grant_valid
);

    logic [NUM_CH-1:0] req_rot;
    int unsigned       offset;
    int unsigned       idx;

    always_comb begin
        // Rotate right by ptr: bit 0 of req_rot is channel ptr.
        req_rot     = NUM_CH'({req, req} >> ptr);
        grant_valid = 1'b0;
        offset      = 0;
        // Descending scan so the lowest set bit wins.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                grant_valid = 1'b1;
                offset      = i;
            end
        end
        idx = 32'(ptr) + offset;
        if (idx >= NUM_CH) begin
            idx = idx - NUM_CH;
        end
        grant = SEL_W'(idx);
    end

endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
// Registered N-to-1 valid/ready stream multiplexer. Arbitrates round-robin or
// under a forced channel select, and keeps the grant on one channel for the
// whole of a multi-beat packet (until a beat with last=1 is transferred).
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid/ready   per-channel handshake (in_ready is one-hot or zero)
//   in_data          channel i at bits [i*DATA_W +: DATA_W]
//   in_last          per-channel end-of-packet flag
//   force_en         1 = serve only force_sel, 0 = round-robin
//   force_sel        forced channel (values >= NUM_CH grant nothing)
//   out_valid/ready  output handshake
//   out_data/last    registered beat data and end-of-packet flag
//   out_ch           source channel of the current output beat
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned NUM_CH = 4,
    localparam int unsigned SEL_W = sel_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_last,
    input  logic                     force_en,
    input  logic [SEL_W-1:0]         force_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [SEL_W-1:0]         out_ch
);

    state_e              state_q;
    logic [SEL_W-1:0]    lock_ch_q;
    logic [SEL_W-1:0]    rr_ptr_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_last_q;
    logic [SEL_W-1:0]    out_ch_q;

    mode_e               mode;
    logic [SEL_W-1:0]    rr_grant;
    logic                rr_grant_valid;
    logic [SEL_W-1:0]    grant;
    logic                grant_valid;
    logic                force_in_range;
    logic                load;
    logic                xfer;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_last;
    logic [SEL_W-1:0]    next_ptr;

    assign mode           = mode_e'(force_en);
    assign force_in_range = (32'(force_sel) < NUM_CH);

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_rr_arbiter (
        .req         (in_valid),
        .ptr         (rr_ptr_q),
        .grant       (rr_grant),
        .grant_valid (rr_grant_valid)
    );

    // Grant source: locked channel beats any mode, then forced, then round-robin.
    always_comb begin
        grant       = rr_grant;
        grant_valid = rr_grant_valid;
        if (state_q == ST_LOCKED) begin
            grant       = lock_ch_q;
            grant_valid = in_valid[lock_ch_q];
        end else if (mode == MODE_FORCE) begin
            grant       = force_sel;
            grant_valid = force_in_range && in_valid[force_sel];
        end
    end

    // Output register may load when empty or being drained this cycle.
    assign load = !out_valid_q || out_ready;
    // rst_n gate keeps in_ready low for the whole reset assertion.
    assign xfer = grant_valid && load && rst_n;

    assign in_ready = xfer ? (NUM_CH'(1) << grant) : '0;

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant == SEL_W'(i)) begin
                sel_data = in_data[i*DATA_W +: DATA_W];
                sel_last = in_last[i];
            end
        end
    end

    assign next_ptr = (32'(grant) == NUM_CH - 1) ? '0 : grant + SEL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lock_ch_q   <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= sel_data;
                out_last_q  <= sel_last;
                out_ch_q    <= grant;
                if (sel_last) begin
                    state_q  <= ST_IDLE;
                    rr_ptr_q <= next_ptr;
                end else if (state_q == ST_IDLE) begin
                    state_q   <= ST_LOCKED;
                    lock_ch_q <= grant;
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;

    localparam int unsigned DATA_W = 128;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_ready;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_last;
    logic                     force_en;
    logic [SEL_W-1:0]         force_sel;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA_W-1:0]        out_data;
    logic                     out_last;
    logic [SEL_W-1:0]         out_ch;

    stream_mux_rr #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .force_en  (force_en),
        .force_sel (force_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ch    (out_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] n;
        logic       last;
    } exp_t;

    exp_t            exp_q[$];
    logic [DATA_W:0] src_q[NUM_CH][$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int prev_cyc = 0;
    bit have_prev = 0;
    bit gap_check = 0;

    function automatic logic [DATA_W-1:0] mk(input int ch, input int n);
        return {32'(ch), 32'(n), 64'hDEAD_BEEF_0000_0000 ^ 64'(n * 7 + ch)};
    endfunction

    task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                         input logic [DATA_W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_src(input int ch, input int n, input bit last);
        src_q[ch].push_back({last, mk(ch, n)});
    endtask

    task automatic push_exp(input int ch, input int n, input bit last);
        exp_t e;
        e.ch   = 2'(ch);
        e.n    = 8'(n);
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic send(input int ch, input int n, input bit last);
        push_src(ch, n, last);
        push_exp(ch, n, last);
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < NUM_CH; i++) begin
            if (src_q[i].size() != 0) begin
                in_valid[i]                 = 1'b1;
                in_data[i*DATA_W +: DATA_W] = src_q[i][0][DATA_W-1:0];
                in_last[i]                  = src_q[i][0][DATA_W];
            end else begin
                in_valid[i]                 = 1'b0;
                in_data[i*DATA_W +: DATA_W] = '0;
                in_last[i]                  = 1'b0;
            end
        end
    endtask

    // One clock: drive, sample handshakes mid-cycle, pass the edge, retire accepted beats.
    task automatic tick();
        logic [NUM_CH-1:0] acc;
        exp_t              e;
        apply_inputs();
        #1;
        check("ready_onehot0", DATA_W'($onehot0(in_ready)), DATA_W'(1));
        check("ready_without_valid", DATA_W'(in_ready & ~in_valid), '0);
        acc = in_ready;
        if (out_valid && out_ready) begin
            check("beat_expected", DATA_W'(exp_q.size() != 0), DATA_W'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_ch", DATA_W'(out_ch), DATA_W'(e.ch));
                check("out_data", out_data, mk(int'(e.ch), int'(e.n)));
                check("out_last", DATA_W'(out_last), DATA_W'(e.last));
                if (gap_check && have_prev) begin
                    check("no_gap", DATA_W'(cyc - prev_cyc), DATA_W'(1));
                end
                prev_cyc  = cyc;
                have_prev = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < NUM_CH; i++) begin
            if (acc[i]) begin
                void'(src_q[i].pop_front());
            end
        end
    endtask

    task automatic drain(input int max_cycles);
        int k = 0;
        while (exp_q.size() != 0 && k < max_cycles) begin
            tick();
            k++;
        end
        check("drain_timeout", DATA_W'(exp_q.size()), '0);
    endtask

    initial begin
        rst_n     = 1'b1;
        out_ready = 1'b1;
        force_en  = 1'b0;
        force_sel = '0;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        #1;
        rst_n = 1'b0;

        // Reset state, with every channel already requesting.
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                send(c, r, 1'b1);
            end
        end
        repeat (2) @(posedge clk);
        apply_inputs();
        #1;
        check("rst_in_ready", DATA_W'(in_ready), '0);
        check("rst_out_valid", DATA_W'(out_valid), '0);
        check("rst_out_data", out_data, '0);
        check("rst_out_last", DATA_W'(out_last), '0);
        check("rst_out_ch", DATA_W'(out_ch), '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round-robin fairness: 0,1,2,3,0,1,2,3 back to back.
        have_prev = 1'b0;
        gap_check = 1'b1;
        drain(20);
        gap_check = 1'b0;

        // Packet lock: move pointer to 1, then ch1 holds the grant for 3 beats.
        send(0, 10, 1'b1);
        drain(10);
        send(1, 0, 1'b0);
        send(1, 1, 1'b0);
        send(1, 2, 1'b1);
        send(2, 10, 1'b1);
        send(3, 10, 1'b1);
        send(0, 11, 1'b1);
        have_prev = 1'b0;
        gap_check = 1'b1;
        drain(20);
        gap_check = 1'b0;

        // Forced mode: ch2 packet survives a mid-packet force_sel change.
        force_en  = 1'b1;
        force_sel = 2'd2;
        send(2, 20, 1'b0);
        send(2, 21, 1'b0);
        send(2, 22, 1'b1);
        send(0, 20, 1'b1);
        push_src(1, 20, 1'b1);
        push_src(3, 20, 1'b1);
        tick();
        force_sel = 2'd0;
        drain(20);
        repeat (4) tick();
        check("forced_ch1_unserved", DATA_W'(src_q[1].size()), DATA_W'(1));
        check("forced_ch3_unserved", DATA_W'(src_q[3].size()), DATA_W'(1));
        // Back to round-robin: resumes after ch0, so ch1 then ch3.
        force_en = 1'b0;
        push_exp(1, 20, 1'b1);
        push_exp(3, 20, 1'b1);
        drain(10);

        // Backpressure: output held 5 cycles, then beats follow with no gap.
        send(0, 30, 1'b0);
        send(0, 31, 1'b0);
        send(0, 32, 1'b1);
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_out_valid", DATA_W'(out_valid), DATA_W'(1));
            check("bp_out_data", out_data, mk(0, 30));
            check("bp_in_ready", DATA_W'(in_ready), '0);
        end
        out_ready = 1'b1;
        have_prev = 1'b0;
        gap_check = 1'b1;
        drain(10);
        gap_check = 1'b0;

        // Wrap and sparse: pointer to 3, only ch1 valid, then pointer ends at 2.
        send(2, 40, 1'b1);
        drain(10);
        send(1, 40, 1'b0);
        send(1, 41, 1'b1);
        drain(10);
        send(2, 42, 1'b1);
        send(3, 42, 1'b1);
        send(0, 42, 1'b1);
        send(1, 42, 1'b1);
        drain(20);

        // Granted channel stalls mid-packet: ch3 must wait.
        send(2, 50, 1'b0);
        push_src(3, 50, 1'b1);
        drain(10);
        repeat (4) tick();
        check("stall_ch3_waits", DATA_W'(src_q[3].size()), DATA_W'(1));
        send(2, 51, 1'b1);
        push_exp(3, 50, 1'b1);
        drain(10);

        // Reset mid-packet on ch3; afterwards ch0 wins first.
        force_en  = 1'b1;
        force_sel = 2'd3;
        send(3, 60, 1'b0);
        push_src(3, 61, 1'b0);
        push_src(0, 60, 1'b1);
        tick();
        tick();
        force_en = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", DATA_W'(out_valid), '0);
        check("midrst_in_ready", DATA_W'(in_ready), '0);
        for (int i = 0; i < NUM_CH; i++) begin
            src_q[i].delete();
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            send(c, 70, 1'b1);
        end
        drain(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised, registered N-to-1 stream multiplexer for the Deflate kernel datapath. It generalises the fixed 4-to-1, 128-bit combinational selector in three ways: it takes NUM_CH valid/ready input channels, arbitrates between them round-robin or under a forced channel select, and holds the grant for the whole of a multi-beat packet. It sits between the parallel compression lanes and the shared output/write-back path, and drives one registered output stage.

## Interface
- DATA_W, 128, data width per channel
- NUM_CH, 4, number of input channels (2..16)
- SEL_W, $clog2(NUM_CH), channel index width (derived, not overridden)

- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  reset, asynchronous assert, active-low
- in_valid  in  NUM_CH  per-channel beat valid
- in_ready  out  NUM_CH  per-channel beat accepted (one-hot or zero)
- in_data  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- in_last  in  NUM_CH  per-channel end-of-packet flag
- force_en  in  1  1 = forced-select mode, 0 = round-robin
- force_sel  in  SEL_W  channel served when force_en=1
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_W  registered beat data
- out_last  out  1  registered end-of-packet flag
- out_ch  out  SEL_W  source channel of the current output beat

## Operation
- FSM states: IDLE (no packet open) and LOCKED (packet open on lock_ch).
- Grant in IDLE, round-robin: the first channel with in_valid=1, searching upward from rr_ptr with wrap NUM_CH-1 -> 0.
- Grant in IDLE, forced: force_sel, and only if in_valid[force_sel]=1. Otherwise there is no grant. Channels not equal to force_sel are never served. A force_sel >= NUM_CH gives no grant.
- Grant in LOCKED: lock_ch only. force_en and force_sel are ignored until the packet closes.
- Transfer: a beat moves when the granted channel has valid=1 and load = (!out_valid || out_ready).
  - in_ready[g] = grant_valid && (g == grant) && load. All other in_ready bits are 0.
- Packet control on a transfer:
  - last=0 in IDLE -> LOCKED, lock_ch = grant.
  - last=1 (either state) -> IDLE, rr_ptr = grant+1 with wrap.
  - A single-beat packet (last=1 from IDLE) stays in IDLE and still advances rr_ptr.
- In forced mode, rr_ptr still advances on packet end. Returning to round-robin resumes from the channel after the last one served.
- No beat is dropped or duplicated. A beat is held in the output register until out_valid && out_ready.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, out_ch=0, rr_ptr=0, state=IDLE, lock_ch=0. in_ready is 0 while rst_n=0.
- Latency: a beat accepted at edge N appears on out_* from edge N to N+1. Throughput is 1 beat/cycle when out_ready is held at 1.
- in_ready depends combinationally on out_ready, in_valid, force_en and force_sel. There is no combinational path from in_data to out_*.
- Simultaneous out_ready=1 and new transfer: the register reloads in the same cycle and out_valid stays 1.
- Backpressure (out_ready=0 with out_valid=1): all in_ready=0, and out_* stays stable.
- Granted channel deasserts valid mid-packet: the block stays LOCKED and waits. No other channel is served.
- Reset asserted mid-packet: the block returns to IDLE immediately. Any partial packet is abandoned, and upstream recovery is the system's responsibility.

## Structure
- Shared package stream_mux_pkg: state enum (ST_IDLE, ST_LOCKED), the mode encoding for force_en, and a clog2-based SEL_W helper.
- Sub-module rr_arbiter (parameter NUM_CH):
  - Inputs: request vector and pointer.
  - Outputs: grant index and grant_valid.
  - Purely combinational rotate/priority-encode/rotate-back.
- Top level holds the FSM, rr_ptr, lock_ch and the output register.

## Test plan
- Round-robin fairness: NUM_CH=4, all channels continuously valid, single-beat packets, out_ready=1 -> out_ch sequence 0,1,2,3,0,…, one beat per cycle.
- Packet lock: ch1 sends a 3-beat packet (last on beat 3) while ch0, ch2 and ch3 are valid -> three consecutive beats with out_ch=1, then out_ch=2.
- Forced mode: force_en=1, force_sel=2, all channels valid -> only ch2 beats. Toggling force_sel to 0 mid-packet leaves ch2 in service until its last beat.
- Backpressure: out_ready held 0 for 5 cycles with out_valid=1 -> out_data is unchanged and in_ready=0. On release, the next beat follows with no gap.
- Wrap and sparse requests: rr_ptr=3 and only ch1 valid -> ch1 granted, and rr_ptr becomes 2 after its last beat.
- Reset mid-packet: rst_n low during a LOCKED packet on ch3 -> out_valid=0 immediately. After release, ch0 is granted first when all channels are valid.
